masked_bv8_inv_stage2_hpc3_multi: RTL and testbench
===================================================

MASKED_BV8_INV_STAGE2_HPC3_MULTI -- requirements
Module: masked_bv8_inv_stage2_hpc3_multi

Interface
REQ-001 Parameter NUM_SHARES, default 2, meaning share count per masked value (legal 2..4).
REQ-002 Parameter NUM_LANES, default 4, meaning parallel independent stage-2 datapaths (legal 1..16).
REQ-003 Localparam LANE_RANDOM = stage_2_hpc3_randoms(NUM_SHARES), meaning fresh random bits per lane per transaction.
REQ-004 in_clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 in_reset  input  1  asynchronous, active-low reset.
REQ-006 in_a0_t1  input  NUM_LANES x bv4_t[NUM_SHARES]  shared high-half operand per lane.
REQ-007 in_a1_t1  input  NUM_LANES x bv4_t[NUM_SHARES]  shared low-half operand per lane.
REQ-008 in_pow4_t1  input  NUM_LANES x bv4_t[NUM_SHARES]  shared GF(2^4) power term per lane.
REQ-009 in_valid  input  1  operand set valid.
REQ-010 in_ready  output  1  block can accept an operand set.
REQ-011 in_random  input  NUM_LANES*LANE_RANDOM  fresh randomness; lane k uses bits [k*LANE_RANDOM +: LANE_RANDOM].
REQ-012 in_rnd_valid  input  1  in_random is fresh this cycle.
REQ-013 in_flush  input  1  synchronous discard of the held result.
REQ-014 out_theta_t2  output  NUM_LANES x bv2_t[NUM_SHARES]  shared theta per lane.
REQ-015 out_mul_a0_t2  output  NUM_LANES x bv4_t[NUM_SHARES]  shared a0*pow4 per lane.
REQ-016 out_mul_a1_t2  output  NUM_LANES x bv4_t[NUM_SHARES]  shared a1*pow4 per lane.
REQ-017 out_valid  output  1  result registers hold an unconsumed result.
REQ-018 out_ready  input  1  consumer accepts result.
REQ-019 out_starve_cnt  output  16  saturating count of cycles stalled only by missing randomness.

Function
REQ-020 Accept SHALL occur when in_valid & in_ready & in_rnd_valid; in_ready = !out_valid | out_ready.
REQ-021 Each lane SHALL split its random slice as {left_p, right_p, theta_p, joint_r}, MSB first, joint_r shared by both HPC3 multipliers and its lower split half feeding theta, identical to existing single-lane stage 2.
REQ-022 Unmasked out_mul_a0_t2 lane k SHALL equal a0_k*pow4_k in the codebase GF(2^4) basis; out_mul_a1_t2 likewise with a1_k; out_theta_t2 SHALL equal the codebase theta of pow4_k.
REQ-023 Latency SHALL be exactly 1 cycle: accept at edge N sets out_valid after edge N with results valid.
REQ-024 All gadget-internal registers SHALL load only on accept; when not accepting they hold, so no random bit is combined with two different operand sets.
REQ-025 Stall (out_valid & !out_ready) SHALL hold all outputs bit-stable, including every share.
REQ-026 out_valid SHALL set on accept, clear on out_ready without accept, stay set on simultaneous consume and accept (back-to-back, full throughput).
REQ-027 in_flush SHALL clear out_valid next edge and override a simultaneous accept (accepted set discarded, randomness consumed); share registers need not clear.
REQ-028 out_starve_cnt SHALL increment when in_valid & in_ready & !in_rnd_valid, saturate at 0xFFFF, never wrap.
REQ-029 Lanes SHALL share handshake state; no cross-lane mixing of shares or randomness.
REQ-030 No output share SHALL be combinationally derived from unregistered inputs.

Reset
REQ-031 in_reset low SHALL immediately clear out_valid, out_starve_cnt and every share register of every output to 0, regardless of clock.
REQ-032 in_ready SHALL be 1 during and after reset; an accept aborted by mid-cycle reset SHALL leave out_valid 0.

Verification
REQ-033 NUM_SHARES=2, NUM_LANES=2, random shares, pow4 unmasked 0 both lanes, one accept -> next cycle out_valid=1, all unmasked mul outputs 0x0, theta equals golden theta(0).
REQ-034 Stream 100 random sets, out_ready=1, in_rnd_valid=1 -> 100 results in 100 consecutive cycles, each unmasked value matching golden model.
REQ-035 out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs bit-stable 5 cycles, out_starve_cnt unchanged.
REQ-036 in_valid=1, in_rnd_valid=0 for 70000 cycles, out_valid=0 -> no accept, out_starve_cnt=0xFFFF, holds.
REQ-037 in_flush with simultaneous accept -> out_valid=0 next cycle; following accept produces correct result.
REQ-038 Assert in_reset low between clock edges while out_valid=1 -> out_valid=0, all shares 0, counter 0 before next edge.

Source files
------------

// File: rtl/masked_bv8_inv_stage2_hpc3_multi.sv
// Stage 2 of a masked GF(2^8) inverter: NUM_LANES independent lanes of HPC3 gadgets computing
// a0*pow4, a1*pow4 (GF(2^4), x^4+x+1) and theta(pow4) = hi*lo in GF(2^2), one cycle latency.

function automatic int stage_2_hpc3_randoms(input int num_shares);
    // Per share pair: left_p (4), right_p (4), theta_p (2) and joint_r (4) bits.
    return 14 * ((num_shares * (num_shares - 1)) / 2);
endfunction

module masked_bv8_inv_stage2_hpc3_multi #(
    parameter  int NUM_SHARES  = 2,
    parameter  int NUM_LANES   = 4,
    localparam int LANE_RANDOM = stage_2_hpc3_randoms(NUM_SHARES)
) (
    input  logic                                     in_clock,
    input  logic                                     in_reset,
    input  logic [NUM_LANES-1:0][NUM_SHARES-1:0][3:0] in_a0_t1,
    input  logic [NUM_LANES-1:0][NUM_SHARES-1:0][3:0] in_a1_t1,
    input  logic [NUM_LANES-1:0][NUM_SHARES-1:0][3:0] in_pow4_t1,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [NUM_LANES*LANE_RANDOM-1:0]         in_random,
    input  logic                                     in_rnd_valid,
    input  logic                                     in_flush,
    output logic [NUM_LANES-1:0][NUM_SHARES-1:0][1:0] out_theta_t2,
    output logic [NUM_LANES-1:0][NUM_SHARES-1:0][3:0] out_mul_a0_t2,
    output logic [NUM_LANES-1:0][NUM_SHARES-1:0][3:0] out_mul_a1_t2,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [15:0]                              out_starve_cnt
);

    localparam int PAIRS     = (NUM_SHARES * (NUM_SHARES - 1)) / 2;
    localparam int THETA_LSB = 4 * PAIRS;
    localparam int RIGHT_LSB = 6 * PAIRS;
    localparam int LEFT_LSB  = 10 * PAIRS;

    typedef logic [NUM_LANES-1:0][NUM_SHARES-1:0][NUM_SHARES-1:0][3:0] nib_terms_t;
    typedef logic [NUM_LANES-1:0][NUM_SHARES-1:0][NUM_SHARES-1:0][1:0] duo_terms_t;

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = 7'h00;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                p[i+j] = p[i+j] ^ (a[i] & b[j]);
            end
        end
        return {p[3] ^ p[6], p[2] ^ p[5] ^ p[6], p[1] ^ p[4] ^ p[5], p[0] ^ p[4]};
    endfunction

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] p;
        p = {a[1] & b[1], (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
        return {p[1] ^ p[2], p[0] ^ p[2]};
    endfunction

    function automatic int pair_index(input int lo, input int hi);
        return lo * NUM_SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    nib_terms_t a0_u_d, a0_v_d, a0_u_q, a0_v_q;
    nib_terms_t a1_u_d, a1_v_d, a1_u_q, a1_v_q;
    duo_terms_t th_u_d, th_v_d, th_u_q, th_v_q;

    logic        accept_s;
    logic        starve_s;
    logic        out_valid_d, out_valid_q;
    logic [15:0] starve_cnt_d, starve_cnt_q;

    // Cross terms x_i*(y_j^r)^r' and x_i*r^r' sum to x_i*y_j once both are registered.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        for (genvar i = 0; i < NUM_SHARES; i++) begin : g_i
            for (genvar j = 0; j < NUM_SHARES; j++) begin : g_j
                if (i == j) begin : g_diag
                    assign a0_u_d[l][i][j] = gf16_mul(in_a0_t1[l][i], in_pow4_t1[l][i]);
                    assign a0_v_d[l][i][j] = 4'h0;
                    assign a1_u_d[l][i][j] = gf16_mul(in_a1_t1[l][i], in_pow4_t1[l][i]);
                    assign a1_v_d[l][i][j] = 4'h0;
                    assign th_u_d[l][i][j] = gf4_mul(in_pow4_t1[l][i][3:2], in_pow4_t1[l][i][1:0]);
                    assign th_v_d[l][i][j] = 2'h0;
                end else begin : g_cross
                    localparam int PI   = (i < j) ? pair_index(i, j) : pair_index(j, i);
                    localparam int BASE = l * LANE_RANDOM;
                    logic [3:0] joint_s, left_s, right_s;
                    logic [1:0] theta_r_s, theta_p_s;
                    assign joint_s   = in_random[BASE + 4*PI +: 4];
                    assign theta_r_s = in_random[BASE + 2*PI +: 2];
                    assign theta_p_s = in_random[BASE + THETA_LSB + 2*PI +: 2];
                    assign right_s   = in_random[BASE + RIGHT_LSB + 4*PI +: 4];
                    assign left_s    = in_random[BASE + LEFT_LSB + 4*PI +: 4];
                    assign a0_u_d[l][i][j] = gf16_mul(in_a0_t1[l][i], in_pow4_t1[l][j] ^ joint_s) ^ left_s;
                    assign a0_v_d[l][i][j] = gf16_mul(in_a0_t1[l][i], joint_s) ^ left_s;
                    assign a1_u_d[l][i][j] = gf16_mul(in_a1_t1[l][i], in_pow4_t1[l][j] ^ joint_s) ^ right_s;
                    assign a1_v_d[l][i][j] = gf16_mul(in_a1_t1[l][i], joint_s) ^ right_s;
                    assign th_u_d[l][i][j] = gf4_mul(in_pow4_t1[l][i][3:2],
                                                     in_pow4_t1[l][j][1:0] ^ theta_r_s) ^ theta_p_s;
                    assign th_v_d[l][i][j] = gf4_mul(in_pow4_t1[l][i][3:2], theta_r_s) ^ theta_p_s;
                end
            end
        end
    end

    // Handshake, result-valid and starvation-counter next state.
    always_comb begin
        in_ready = ~out_valid_q | out_ready;
        accept_s = in_valid & in_ready & in_rnd_valid;
        starve_s = in_valid & in_ready & ~in_rnd_valid;
        if (in_flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (starve_s && (starve_cnt_q != 16'hFFFF)) begin
            starve_cnt_d = starve_cnt_q + 16'h0001;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Gadget registers load only on accept so each random draw meets exactly one operand set.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            a0_u_q <= '0;
            a0_v_q <= '0;
            a1_u_q <= '0;
            a1_v_q <= '0;
            th_u_q <= '0;
            th_v_q <= '0;
        end else if (accept_s) begin
            a0_u_q <= a0_u_d;
            a0_v_q <= a0_v_d;
            a1_u_q <= a1_u_d;
            a1_v_q <= a1_v_d;
            th_u_q <= th_u_d;
            th_v_q <= th_v_d;
        end
    end

    // Control state.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            out_valid_q  <= 1'b0;
            starve_cnt_q <= 16'h0000;
        end else begin
            out_valid_q  <= out_valid_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Output share i is the XOR of all registered terms of row i.
    always_comb begin
        out_mul_a0_t2 = '0;
        out_mul_a1_t2 = '0;
        out_theta_t2  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int i = 0; i < NUM_SHARES; i++) begin
                for (int j = 0; j < NUM_SHARES; j++) begin
                    out_mul_a0_t2[l][i] = out_mul_a0_t2[l][i] ^ a0_u_q[l][i][j] ^ a0_v_q[l][i][j];
                    out_mul_a1_t2[l][i] = out_mul_a1_t2[l][i] ^ a1_u_q[l][i][j] ^ a1_v_q[l][i][j];
                    out_theta_t2[l][i]  = out_theta_t2[l][i] ^ th_u_q[l][i][j] ^ th_v_q[l][i][j];
                end
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_masked_bv8_inv_stage2_hpc3_multi.sv
// Directed self-checking bench for masked_bv8_inv_stage2_hpc3_multi (2 shares, 2 lanes).
module tb_masked_bv8_inv_stage2_hpc3_multi;
    localparam int NS = 2;
    localparam int NL = 2;
    localparam int LR = 14;
    localparam int RW = NL * LR;
    localparam int OW = NL * NS * 10;

    logic                       in_clock, in_reset;
    logic [NL-1:0][NS-1:0][3:0] in_a0_t1, in_a1_t1, in_pow4_t1;
    logic                       in_valid, in_ready, in_rnd_valid, in_flush;
    logic [RW-1:0]              in_random;
    logic [NL-1:0][NS-1:0][1:0] out_theta_t2;
    logic [NL-1:0][NS-1:0][3:0] out_mul_a0_t2, out_mul_a1_t2;
    logic                       out_valid, out_ready;
    logic [15:0]                out_starve_cnt;

    logic [3:0] exp_a0 [NL];
    logic [3:0] exp_a1 [NL];
    logic [1:0] exp_th [NL];
    int n_cmp = 0;
    int n_fail = 0;

    masked_bv8_inv_stage2_hpc3_multi #(.NUM_SHARES(NS), .NUM_LANES(NL)) dut (
        .in_clock(in_clock), .in_reset(in_reset),
        .in_a0_t1(in_a0_t1), .in_a1_t1(in_a1_t1), .in_pow4_t1(in_pow4_t1),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_random(in_random), .in_rnd_valid(in_rnd_valid), .in_flush(in_flush),
        .out_theta_t2(out_theta_t2), .out_mul_a0_t2(out_mul_a0_t2), .out_mul_a1_t2(out_mul_a1_t2),
        .out_valid(out_valid), .out_ready(out_ready), .out_starve_cnt(out_starve_cnt)
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    function automatic logic [3:0] m_gf16(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc, x;
        acc = 4'h0;
        x = a;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) acc = acc ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    function automatic logic [1:0] m_gf4(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] acc, x;
        acc = 2'h0;
        x = a;
        for (int k = 0; k < 2; k++) begin
            if (b[k]) acc = acc ^ x;
            x = {x[0], 1'b0} ^ (x[1] ? 2'h3 : 2'h0);
        end
        return acc;
    endfunction

    function automatic logic [1:0] m_theta(input logic [3:0] v);
        return m_gf4(v[3:2], v[1:0]);
    endfunction

    function automatic logic [3:0] um4(input logic [NS-1:0][3:0] v);
        logic [3:0] acc;
        acc = 4'h0;
        for (int s = 0; s < NS; s++) acc = acc ^ v[s];
        return acc;
    endfunction

    function automatic logic [1:0] um2(input logic [NS-1:0][1:0] v);
        logic [1:0] acc;
        acc = 2'h0;
        for (int s = 0; s < NS; s++) acc = acc ^ v[s];
        return acc;
    endfunction

    // Drive freshly masked operands and randomness, and record the model result.
    task automatic load_set(input logic [NL-1:0][3:0] va0, input logic [NL-1:0][3:0] va1,
                            input logic [NL-1:0][3:0] vpw);
        logic [3:0] m;
        for (int l = 0; l < NL; l++) begin
            m = 4'($urandom); in_a0_t1[l][0] = m;   in_a0_t1[l][1] = va0[l] ^ m;
            m = 4'($urandom); in_a1_t1[l][0] = m;   in_a1_t1[l][1] = va1[l] ^ m;
            m = 4'($urandom); in_pow4_t1[l][0] = m; in_pow4_t1[l][1] = vpw[l] ^ m;
            exp_a0[l] = m_gf16(va0[l], vpw[l]);
            exp_a1[l] = m_gf16(va1[l], vpw[l]);
            exp_th[l] = m_theta(vpw[l]);
        end
        in_random = RW'($urandom);
    endtask

    task automatic test_reset();
        in_reset = 1'b0; in_valid = 1'b1; in_rnd_valid = 1'b1; in_flush = 1'b0; out_ready = 1'b0;
        in_a0_t1 = '0; in_a1_t1 = '0; in_pow4_t1 = '0; in_random = '0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", in_ready); end
        n_cmp++; if (out_starve_cnt !== 16'h0000) begin n_fail++; $display("FAIL rst_cnt got %h want 0000", out_starve_cnt); end
        n_cmp++; if ({out_mul_a0_t2, out_mul_a1_t2, out_theta_t2} !== {OW{1'b0}}) begin
            n_fail++; $display("FAIL rst_shares got %h want 0", {out_mul_a0_t2, out_mul_a1_t2, out_theta_t2}); end
        repeat (2) @(posedge in_clock);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid got %b want 0", out_valid); end
        in_reset = 1'b1; in_valid = 1'b0;
        @(posedge in_clock); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_idle_valid got %b want 0", out_valid); end
    endtask

    task automatic test_zero_pow();
        load_set(8'($urandom), 8'($urandom), 8'h00);
        in_valid = 1'b1; in_rnd_valid = 1'b1; out_ready = 1'b1;
        @(posedge in_clock); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid got %b want 1", out_valid); end
        for (int l = 0; l < NL; l++) begin
            n_cmp++; if (um4(out_mul_a0_t2[l]) !== 4'h0) begin n_fail++; $display("FAIL zero_a0 lane%0d got %h want 0", l, um4(out_mul_a0_t2[l])); end
            n_cmp++; if (um4(out_mul_a1_t2[l]) !== 4'h0) begin n_fail++; $display("FAIL zero_a1 lane%0d got %h want 0", l, um4(out_mul_a1_t2[l])); end
            n_cmp++; if (um2(out_theta_t2[l]) !== m_theta(4'h0)) begin n_fail++; $display("FAIL zero_theta lane%0d got %h want %h", l, um2(out_theta_t2[l]), m_theta(4'h0)); end
        end
    endtask

    task automatic test_directed();
        logic [NL-1:0][3:0] want_a0, want_a1;
        logic [NL-1:0][1:0] want_th;
        want_a0 = {4'hF, 4'h3};
        want_a1 = {4'h1, 4'hB};
        want_th = {2'h1, 2'h0};
        load_set({4'h2, 4'h2}, {4'h3, 4'h3}, {4'hE, 4'h8});
        in_valid = 1'b1;
        @(posedge in_clock); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir_valid got %b want 1", out_valid); end
        for (int l = 0; l < NL; l++) begin
            n_cmp++; if (um4(out_mul_a0_t2[l]) !== want_a0[l]) begin n_fail++; $display("FAIL dir_a0 lane%0d got %h want %h", l, um4(out_mul_a0_t2[l]), want_a0[l]); end
            n_cmp++; if (um4(out_mul_a1_t2[l]) !== want_a1[l]) begin n_fail++; $display("FAIL dir_a1 lane%0d got %h want %h", l, um4(out_mul_a1_t2[l]), want_a1[l]); end
            n_cmp++; if (um2(out_theta_t2[l]) !== want_th[l]) begin n_fail++; $display("FAIL dir_theta lane%0d got %h want %h", l, um2(out_theta_t2[l]), want_th[l]); end
        end
        @(posedge in_clock); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_rnd_valid = 1'b1; in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            load_set(8'($urandom), 8'($urandom), 8'($urandom));
            @(posedge in_clock); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid set%0d got %b want 1", n, out_valid); end
            for (int l = 0; l < NL; l++) begin
                n_cmp++; if (um4(out_mul_a0_t2[l]) !== exp_a0[l]) begin n_fail++; $display("FAIL b2b_a0 set%0d lane%0d got %h want %h", n, l, um4(out_mul_a0_t2[l]), exp_a0[l]); end
                n_cmp++; if (um4(out_mul_a1_t2[l]) !== exp_a1[l]) begin n_fail++; $display("FAIL b2b_a1 set%0d lane%0d got %h want %h", n, l, um4(out_mul_a1_t2[l]), exp_a1[l]); end
                n_cmp++; if (um2(out_theta_t2[l]) !== exp_th[l]) begin n_fail++; $display("FAIL b2b_theta set%0d lane%0d got %h want %h", n, l, um2(out_theta_t2[l]), exp_th[l]); end
            end
        end
        in_valid = 1'b0;
        @(posedge in_clock); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [3:0]    s_a0 [NL];
        logic [3:0]    s_a1 [NL];
        logic [1:0]    s_th [NL];
        logic [OW-1:0] snap;
        load_set(8'($urandom), 8'($urandom), 8'($urandom));
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge in_clock); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_first got %b want 1", out_valid); end
        s_a0 = exp_a0; s_a1 = exp_a1; s_th = exp_th;
        snap = {out_mul_a0_t2, out_mul_a1_t2, out_theta_t2};
        out_ready = 1'b0;
        load_set(8'($urandom), 8'($urandom), 8'($urandom));
        for (int k = 0; k < 5; k++) begin
            in_rnd_valid = (k % 2 == 0) ? 1'b0 : 1'b1;
            in_random = RW'($urandom);
            @(posedge in_clock); #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc%0d got %b want 0", k, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc%0d got %b want 1", k, out_valid); end
            n_cmp++; if ({out_mul_a0_t2, out_mul_a1_t2, out_theta_t2} !== snap) begin
                n_fail++; $display("FAIL stall_shares cyc%0d got %h want %h", k, {out_mul_a0_t2, out_mul_a1_t2, out_theta_t2}, snap); end
            n_cmp++; if (out_starve_cnt !== 16'h0000) begin n_fail++; $display("FAIL stall_cnt cyc%0d got %h want 0000", k, out_starve_cnt); end
            for (int l = 0; l < NL; l++) begin
                n_cmp++; if ({um4(out_mul_a0_t2[l]), um4(out_mul_a1_t2[l]), um2(out_theta_t2[l])} !== {s_a0[l], s_a1[l], s_th[l]}) begin
                    n_fail++; $display("FAIL stall_value cyc%0d lane%0d got %h want %h", k, l,
                        {um4(out_mul_a0_t2[l]), um4(out_mul_a1_t2[l]), um2(out_theta_t2[l])}, {s_a0[l], s_a1[l], s_th[l]}); end
            end
        end
        out_ready = 1'b1; in_rnd_valid = 1'b1;
        @(posedge in_clock); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b want 1", out_valid); end
        for (int l = 0; l < NL; l++) begin
            n_cmp++; if ({um4(out_mul_a0_t2[l]), um4(out_mul_a1_t2[l]), um2(out_theta_t2[l])} !== {exp_a0[l], exp_a1[l], exp_th[l]}) begin
                n_fail++; $display("FAIL stall_next lane%0d got %h want %h", l,
                    {um4(out_mul_a0_t2[l]), um4(out_mul_a1_t2[l]), um2(out_theta_t2[l])}, {exp_a0[l], exp_a1[l], exp_th[l]}); end
        end
        @(posedge in_clock); #1;
    endtask

    task automatic test_starve();
        out_ready = 1'b1; in_valid = 1'b1; in_rnd_valid = 1'b0;
        repeat (10) @(posedge in_clock);
        #1;
        n_cmp++; if (out_starve_cnt !== 16'd10) begin n_fail++; $display("FAIL starve_10 got %0d want 10", out_starve_cnt); end
        repeat (65525) @(posedge in_clock);
        #1;
        n_cmp++; if (out_starve_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL starve_sat got %h want ffff", out_starve_cnt); end
        repeat (4465) @(posedge in_clock);
        #1;
        n_cmp++; if (out_starve_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL starve_hold got %h want ffff", out_starve_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL starve_valid got %b want 0", out_valid); end
        in_valid = 1'b0; in_rnd_valid = 1'b1;
    endtask

    task automatic test_flush();
        load_set(8'($urandom), 8'($urandom), 8'($urandom));
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge in_clock); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got %b want 1", out_valid); end
        in_valid = 1'b0; out_ready = 1'b0; in_flush = 1'b1;
        @(posedge in_clock); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_held got %b want 0", out_valid); end
        load_set(8'($urandom), 8'($urandom), 8'($urandom));
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge in_clock); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept got %b want 0", out_valid); end
        in_flush = 1'b0;
        load_set(8'($urandom), 8'($urandom), 8'($urandom));
        @(posedge in_clock); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_after got %b want 1", out_valid); end
        for (int l = 0; l < NL; l++) begin
            n_cmp++; if ({um4(out_mul_a0_t2[l]), um4(out_mul_a1_t2[l]), um2(out_theta_t2[l])} !== {exp_a0[l], exp_a1[l], exp_th[l]}) begin
                n_fail++; $display("FAIL flush_value lane%0d got %h want %h", l,
                    {um4(out_mul_a0_t2[l]), um4(out_mul_a1_t2[l]), um2(out_theta_t2[l])}, {exp_a0[l], exp_a1[l], exp_th[l]}); end
        end
        @(posedge in_clock); #1;
    endtask

    task automatic test_async_reset();
        load_set(8'($urandom), 8'($urandom), 8'($urandom));
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge in_clock); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %b want 1", out_valid); end
        #2;
        in_reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b want 0", out_valid); end
        n_cmp++; if (out_starve_cnt !== 16'h0000) begin n_fail++; $display("FAIL arst_cnt got %h want 0000", out_starve_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready got %b want 1", in_ready); end
        n_cmp++; if ({out_mul_a0_t2, out_mul_a1_t2, out_theta_t2} !== {OW{1'b0}}) begin
            n_fail++; $display("FAIL arst_shares got %h want 0", {out_mul_a0_t2, out_mul_a1_t2, out_theta_t2}); end
        @(posedge in_clock); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_abort got %b want 0", out_valid); end
        #2;
        in_reset = 1'b1; in_valid = 1'b0;
        @(posedge in_clock); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_zero_pow();
        test_directed();
        test_back_to_back();
        test_stall();
        test_starve();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
